// File: rtl/styler_pkg.sv
// -----------------------------------------------------------------------------
// styler_pkg
// Shared types and constants for the frame-level styler sequencer:
//   - sequencer state enum (IDLE / RUN / DRAIN)
//   - cell geometry (16 scanlines per cell, 8-bit row/column addresses)
//   - output FIFO entry {data, sol, eol, eof}
//   - raster-order cell address stepping helpers, shared by the request
//     and response counters so both walk the frame identically
// -----------------------------------------------------------------------------
package styler_pkg;

    localparam int SCANLINES = 16;
    localparam int SCAN_W    = 4;
    localparam int ROW_W     = 8;
    localparam int COL_W     = 8;
    localparam int WORD_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              sol;
        logic              eol;
        logic              eof;
    } pix_entry_t;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [SCAN_W-1:0] scan;
        logic [COL_W-1:0]  col;
    } cell_addr_t;

    // Raster step: column fastest, then scanline, then row.
    function automatic cell_addr_t cell_next(input cell_addr_t cur,
                                             input logic [COL_W-1:0] col_last);
        cell_addr_t nxt;
        nxt = cur;
        if (cur.col == col_last) begin
            nxt.col  = '0;
            // 4-bit scanline wraps 15 -> 0 on its own.
            nxt.scan = cur.scan + 1'b1;
            if (cur.scan == SCAN_W'(SCANLINES - 1)) begin
                nxt.row = cur.row + 1'b1;
            end
        end else begin
            nxt.col = cur.col + 1'b1;
        end
        return nxt;
    endfunction

    function automatic logic cell_is_last(input cell_addr_t cur,
                                          input logic [ROW_W-1:0] row_last,
                                          input logic [COL_W-1:0] col_last);
        return (cur.row == row_last) &&
               (cur.scan == SCAN_W'(SCANLINES - 1)) &&
               (cur.col == col_last);
    endfunction

endpackage

// File: rtl/styler_seq_fifo.sv
// -----------------------------------------------------------------------------
// styler_seq_fifo
// Two-entry synchronous FIFO holding styled words for the pixel serializer.
// The head entry is read straight from storage, so it is registered.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (flushes the FIFO)
//   push_i, data_i write request and entry
//   pop_i          read request (caller only pops when count_o != 0)
//   head_o         entry at the head (meaningful only when count_o != 0)
//   count_o        number of stored entries, 0..2
// -----------------------------------------------------------------------------
module styler_seq_fifo
    import styler_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  pix_entry_t data_i,
    input  logic       pop_i,
    output pix_entry_t head_o,
    output logic [1:0] count_o
);

    pix_entry_t mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    // A push into a full FIFO is only legal when the head leaves that cycle.
    assign do_push = push_i && ((count_q != 2'd2) || pop_i);
    assign do_pop  = pop_i && (count_q != 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: storage is deliberately not reset; emptiness is tracked by
    // count_q and consumers qualify the head with the count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/styler_sequencer.sv
// -----------------------------------------------------------------------------
// styler_sequencer
// Walks a COLS x ROWS text frame (row -> scanline -> column), issues one
// fetch/style request per cell-scanline, and buffers the in-order styled
// words in a 2-entry FIFO for the pixel serializer. Also owns the per-frame
// faint/blink/cursor phase signals and the per-cell cursor enable.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   frame_start                 pulse: start a frame (ignored while busy)
//   cursor_row, cursor_col      cursor cell position
//   req_valid/req_ready         request handshake to the fetch path
//   req_row/col/scanline/cursor request payload
//   resp_valid, resp_bitmap     in-order styled word from the datapath
//   pix_valid/pix_ready         output word handshake to the serializer
//   pix_data/sol/eol/eof        output word and its position tags
//   faint/blink/cursor_phase    frame-rate phases, constant within a frame
//   busy                        frame in progress
//   overrun                     pulse: frame_start arrived while busy
// -----------------------------------------------------------------------------
module styler_sequencer
    import styler_pkg::*;
#(
    parameter int COLS       = 80,
    parameter int ROWS       = 25,
    parameter int BLINK_DIV  = 32,
    parameter int CURSOR_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [ROW_W-1:0]  cursor_row,
    input  logic [COL_W-1:0]  cursor_col,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ROW_W-1:0]  req_row,
    output logic [COL_W-1:0]  req_col,
    output logic [SCAN_W-1:0] req_scanline,
    output logic              req_cursor,
    input  logic              resp_valid,
    input  logic [WORD_W-1:0] resp_bitmap,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [WORD_W-1:0] pix_data,
    output logic              pix_sol,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              faint_phase,
    output logic              blink_phase,
    output logic              cursor_phase,
    output logic              busy,
    output logic              overrun
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam int BLINK_W  = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
    localparam int CURSOR_W = (CURSOR_DIV > 1) ? $clog2(CURSOR_DIV) : 1;
    localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
    localparam logic [CURSOR_W-1:0] CURSOR_LAST = CURSOR_W'(CURSOR_DIV - 1);

    seq_state_e          state_q, state_d;
    cell_addr_t          req_q, req_d;
    cell_addr_t          rsp_q, rsp_d;
    logic [1:0]          out_q, out_d;
    logic                faint_q, faint_d;
    logic                blink_q, blink_d;
    logic                cphase_q, cphase_d;
    logic                overrun_q, overrun_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic [CURSOR_W-1:0] cursor_cnt_q, cursor_cnt_d;

    logic       credit_ok;
    logic       req_fire;
    logic       rsp_take;
    logic       pix_pop;
    logic [1:0] fifo_cnt;
    pix_entry_t fifo_head;
    pix_entry_t push_entry;

    // Credits cover words in flight plus words buffered, so the FIFO can
    // never be asked to hold a third word.
    assign credit_ok = ({1'b0, out_q} + {1'b0, fifo_cnt}) < 3'd2;
    assign req_valid = (state_q == ST_RUN) && credit_ok;
    assign req_fire  = req_valid && req_ready;
    // Responses with nothing outstanding belong to a flushed frame.
    assign rsp_take  = resp_valid && (out_q != 2'd0);
    assign pix_pop   = pix_valid && pix_ready;

    assign push_entry.data = resp_bitmap;
    assign push_entry.sol  = (rsp_q.col == '0);
    assign push_entry.eol  = (rsp_q.col == COL_LAST);
    assign push_entry.eof  = cell_is_last(rsp_q, ROW_LAST, COL_LAST);

    styler_seq_fifo u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rsp_take),
        .data_i  (push_entry),
        .pop_i   (pix_pop),
        .head_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    // NOTE: every next-state variable is given its hold value first so no
    // path through the block leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        rsp_d        = rsp_q;
        faint_d      = faint_q;
        blink_d      = blink_q;
        cphase_d     = cphase_q;
        blink_cnt_d  = blink_cnt_q;
        cursor_cnt_d = cursor_cnt_q;
        overrun_d    = frame_start && (state_q != ST_IDLE);
        out_d        = out_q + {1'b0, req_fire} - {1'b0, rsp_take};

        if (rsp_take) begin
            rsp_d = cell_next(rsp_q, COL_LAST);
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_RUN;
                    req_d   = '0;
                    rsp_d   = '0;
                    out_d   = '0;
                    faint_d = ~faint_q;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                    if (cursor_cnt_q == CURSOR_LAST) begin
                        cursor_cnt_d = '0;
                        cphase_d     = ~cphase_q;
                    end else begin
                        cursor_cnt_d = cursor_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (req_fire) begin
                    req_d = cell_next(req_q, COL_LAST);
                    if (cell_is_last(req_q, ROW_LAST, COL_LAST)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that pops the last word so busy drops
                // the cycle right after it.
                if ((out_q == 2'd0) &&
                    ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pix_pop))) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            rsp_q        <= '0;
            out_q        <= '0;
            faint_q      <= 1'b0;
            blink_q      <= 1'b0;
            cphase_q     <= 1'b0;
            overrun_q    <= 1'b0;
            blink_cnt_q  <= '0;
            cursor_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            rsp_q        <= rsp_d;
            out_q        <= out_d;
            faint_q      <= faint_d;
            blink_q      <= blink_d;
            cphase_q     <= cphase_d;
            overrun_q    <= overrun_d;
            blink_cnt_q  <= blink_cnt_d;
            cursor_cnt_q <= cursor_cnt_d;
        end
    end

    assign req_row      = req_q.row;
    assign req_col      = req_q.col;
    assign req_scanline = req_q.scan;
    // Qualified by req_valid so the enable is quiet outside live requests.
    assign req_cursor   = req_valid && (req_q.row == cursor_row) && (req_q.col == cursor_col);

    assign pix_valid = (fifo_cnt != 2'd0);
    assign pix_data  = pix_valid ? fifo_head.data : '0;
    assign pix_sol   = pix_valid && fifo_head.sol;
    assign pix_eol   = pix_valid && fifo_head.eol;
    assign pix_eof   = pix_valid && fifo_head.eof;

    assign faint_phase  = faint_q;
    assign blink_phase  = blink_q;
    assign cursor_phase = cphase_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_styler_sequencer.sv
// -----------------------------------------------------------------------------
// tb_styler_sequencer
// Drives whole frames through styler_sequencer with a fetch-path model that
// answers each accepted request in order after a randomised latency, and a
// serializer that pulls words with random or scripted back-pressure.
// Expectations come from the frame geometry: the k-th request / word of a
// frame belongs to cell (k / (16*COLS), (k / COLS) % 16, k % COLS); credits
// in use equal requests accepted minus words popped.
// -----------------------------------------------------------------------------
module tb_styler_sequencer;

    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int TOTAL = COLS * ROWS * 16;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [7:0]  cursor_row;
    logic [7:0]  cursor_col;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_row;
    logic [7:0]  req_col;
    logic [3:0]  req_scanline;
    logic        req_cursor;
    logic        resp_valid;
    logic [15:0] resp_bitmap;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic        pix_sol;
    logic        pix_eol;
    logic        pix_eof;
    logic        faint_phase;
    logic        blink_phase;
    logic        cursor_phase;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;

    styler_sequencer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .BLINK_DIV  (2),
        .CURSOR_DIV (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_row      (req_row),
        .req_col      (req_col),
        .req_scanline (req_scanline),
        .req_cursor   (req_cursor),
        .resp_valid   (resp_valid),
        .resp_bitmap  (resp_bitmap),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .pix_sol      (pix_sol),
        .pix_eol      (pix_eol),
        .pix_eof      (pix_eof),
        .faint_phase  (faint_phase),
        .blink_phase  (blink_phase),
        .cursor_phase (cursor_phase),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         lat_min;
        int         lat_max;
        int         req_pct;
        int         pix_pct;
        int         stall_at;   // word index where pix_ready drops for 10 cycles, -1 none
        int         ovr_at;     // request count at which a stray frame_start is sent, -1 none
        logic [7:0] crow;
        logic [7:0] ccol;
        int         exp_hits;   // requests expected to carry req_cursor
        logic       exp_faint;
        logic       exp_blink;
        logic       exp_cursor;
    } scen_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic string nm(input int tag, input string what);
        return $sformatf("f%0d.%s", tag, what);
    endfunction

    function automatic void cell_of(input int k, output int r, output int s, output int c);
        c = k % COLS;
        s = (k / COLS) % 16;
        r = k / (COLS * 16);
    endfunction

    task automatic check_all_zero(input string name);
        check(name, {req_valid, req_row, req_col, req_scanline, req_cursor,
                     pix_valid, pix_data, pix_sol, pix_eol, pix_eof,
                     faint_phase, blink_phase, cursor_phase, busy, overrun}, 64'd0);
    endtask

    // Runs one frame from an idle DUT. With abort_at >= 0 it returns as soon
    // as that many requests have been accepted, leaving the frame in flight.
    task automatic run_frame(input scen_t sc, input int tag, input int abort_at);
        int          accepted   = 0;
        int          responded  = 0;
        int          popped     = 0;
        int          hits       = 0;
        int          max_out    = 0;
        int          stall_left = 0;
        int          last_due   = -1;
        int          lat;
        int          r, s, c;
        bit          stall_done = 0;
        bit          stall_chk  = 0;
        bit          ovr_done   = 0;
        bit          ovr_prev   = 0;
        bit          finished   = 0;
        int          due_q[$];
        logic [15:0] log_q[$];

        cursor_row  = sc.crow;
        cursor_col  = sc.ccol;
        req_ready   = 1'b0;
        pix_ready   = 1'b0;
        resp_valid  = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            // Compare the state left by the previous clock edge.
            check(nm(tag, "busy"), busy, popped < TOTAL);
            check(nm(tag, "req_valid"), req_valid, (accepted < TOTAL) && (accepted - popped < 2));
            check(nm(tag, "pix_valid"), pix_valid, responded > popped);
            check(nm(tag, "overrun"), overrun, ovr_prev);
            check(nm(tag, "phases"), {faint_phase, blink_phase, cursor_phase},
                  {sc.exp_faint, sc.exp_blink, sc.exp_cursor});
            if (req_valid && accepted < TOTAL) begin
                cell_of(accepted, r, s, c);
                check(nm(tag, "req_cell"), {req_row, req_scanline, req_col}, {8'(r), 4'(s), 8'(c)});
                check(nm(tag, "req_cursor"), req_cursor, (r == int'(sc.crow)) && (c == int'(sc.ccol)));
            end
            if (responded > popped) begin
                cell_of(popped, r, s, c);
                check(nm(tag, "pix_word"), {pix_data, pix_sol, pix_eol, pix_eof},
                      {log_q[popped], c == 0, c == COLS - 1, popped == TOTAL - 1});
            end
            if (stall_chk) begin
                stall_chk = 0;
                check(nm(tag, "stall_pix_valid"), pix_valid, 1'b1);
                check(nm(tag, "stall_req_valid"), req_valid, 1'b0);
                check(nm(tag, "stall_words_held"), accepted - popped, 2);
            end
            if (popped == TOTAL) begin
                finished = 1;
                break;
            end
            if (accepted == abort_at) begin
                break;
            end

            // Fetch path: answer the oldest request once its latency is up.
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                resp_valid  = 1'b1;
                resp_bitmap = 16'($urandom);
                log_q.push_back(resp_bitmap);
                responded++;
            end else begin
                resp_valid  = 1'b0;
                resp_bitmap = 16'($urandom);
            end

            req_ready = ($urandom_range(99, 0) < sc.req_pct);
            if (req_valid && req_ready && accepted < TOTAL) begin
                lat      = int'($urandom_range(sc.lat_max, sc.lat_min));
                last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                due_q.push_back(last_due);
                if (req_cursor) hits++;
                accepted++;
            end
            if (accepted - responded > max_out) max_out = accepted - responded;

            if (stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
                if (stall_left == 0) stall_chk = 1;
            end else if (sc.stall_at >= 0 && !stall_done && popped == sc.stall_at) begin
                stall_done = 1;
                stall_left = 9;
                pix_ready  = 1'b0;
            end else begin
                pix_ready = ($urandom_range(99, 0) < sc.pix_pct);
            end
            if (pix_valid && pix_ready && responded > popped) popped++;

            ovr_prev = 0;
            frame_start = 1'b0;
            if (sc.ovr_at >= 0 && !ovr_done && accepted >= sc.ovr_at) begin
                ovr_done    = 1;
                ovr_prev    = 1;
                frame_start = 1'b1;
            end

            @(negedge clk);
        end

        frame_start = 1'b0;
        resp_valid  = 1'b0;
        req_ready   = 1'b0;
        pix_ready   = 1'b0;
        if (abort_at < 0) begin
            check(nm(tag, "frame_completed"), finished, 1'b1);
            check(nm(tag, "cursor_hits"), hits, sc.exp_hits);
            check(nm(tag, "max_outstanding_le_2"), max_out <= 2, 1'b1);
        end
    endtask

    initial begin
        scen_t scen [6];
        scen_t sc_abort;
        scen_t sc_after;

        //          lat  lat  req  pix  stall ovr  crow  ccol  hits  faint blink cursor
        scen[0] = '{1,   1,   100, 100, -1,   -1,  8'd0, 8'd2, 16,   1'b1, 1'b0, 1'b0};
        scen[1] = '{3,   3,   100, 100, -1,   -1,  8'd1, 8'd3, 16,   1'b0, 1'b1, 1'b0};
        scen[2] = '{1,   1,   100, 100, 40,   -1,  8'd5, 8'd0, 0,    1'b1, 1'b1, 1'b1};
        scen[3] = '{1,   4,   70,  70,  -1,   -1,  8'd1, 8'd0, 16,   1'b0, 1'b0, 1'b1};
        scen[4] = '{2,   2,   100, 100, -1,   20,  8'd0, 8'd0, 16,   1'b1, 1'b0, 1'b1};
        scen[5] = '{1,   3,   80,  60,  -1,   -1,  8'd0, 8'd3, 16,   1'b0, 1'b1, 1'b0};
        sc_abort = '{2,  2,   100, 100, -1,   -1,  8'd0, 8'd0, 16,   1'b1, 1'b1, 1'b0};
        sc_after = '{1,  2,   90,  90,  -1,   -1,  8'd0, 8'd0, 16,   1'b1, 1'b0, 1'b0};

        rst         = 1'b1;
        frame_start = 1'b0;
        cursor_row  = 8'd0;
        cursor_col  = 8'd0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_bitmap = 16'd0;
        pix_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_outputs");

        for (int i = 0; i < 6; i++) begin
            run_frame(scen[i], i + 1, -1);
            @(negedge clk);
        end

        // Reset in the middle of a frame, then feed responses that belong to
        // the flushed frame: they must not appear at the output.
        run_frame(sc_abort, 7, 30);
        rst        = 1'b1;
        resp_valid = 1'b0;
        @(negedge clk);
        check_all_zero("midframe_reset_outputs");
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_valid  = 1'b1;
            resp_bitmap = 16'hBEEF;
            @(negedge clk);
            check({"late_resp_pix_valid_", 8'(8'h30 + i)}, pix_valid, 1'b0);
            check({"late_resp_busy_", 8'(8'h30 + i)}, busy, 1'b0);
        end
        resp_valid = 1'b0;
        @(negedge clk);

        run_frame(sc_after, 8, -1);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
